// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and types for the branch predictor / BTB
package bp_pkg;

  // RV32 branch condition codes (func3)
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // 2-bit saturating counter states; the MSB is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // sequential instruction stride
  localparam int PC_INCREASE = 4;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating counter next-state logic
import bp_pkg::*;

module bp_sat_counter (
  input  ctr_t ctr,
  input  logic inc,
  input  logic force_st,
  output ctr_t ctr_next
);

  logic [1:0] raw;

  // force to strongly-taken, else saturating step up or down
  always_comb begin
    raw = ctr;
    if (force_st) begin
      raw = ST;
    end else if (inc) begin
      if (ctr != ST) raw = ctr + 2'd1;
    end else begin
      if (ctr != SNT) raw = ctr - 2'd1;
    end
    ctr_next = ctr_t'(raw);
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - BTB with 2-bit counters; BP_STATS_EN adds branch/mispredict counters
import bp_pkg::*;

module branch_predictor_btb #(
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 16,
  parameter int INDEX_W = $clog2(ENTRIES),
  parameter int TAG_W   = DATA_W - 2 - INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_pc,
  input  logic [DATA_W-1:0] res_imm,
  input  logic [2:0]        res_func3,
  input  logic              res_is_jump,
  input  logic [DATA_W-1:0] res_rs1,
  input  logic [DATA_W-1:0] res_rs2,
  input  logic              res_pred_taken,
  input  logic [DATA_W-1:0] res_pred_target,
  output logic              res_mispredict,
`ifdef BP_STATS_EN
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts,
`endif
  output logic [DATA_W-1:0] res_redirect_pc
);

  // table storage: valid and ctr are reset, tag and target are not
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [DATA_W-1:0] target_q [ENTRIES];
  ctr_t              ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [INDEX_W-1:0] res_idx;
  logic [TAG_W-1:0]   res_tag;
  logic               res_hit;
  logic               cond;
  logic               res_taken;
  logic [DATA_W-1:0]  res_target;
  logic [DATA_W-1:0]  res_fallthrough;
  ctr_t               ctr_next;

  assign lk_idx  = if_pc[INDEX_W+1:2];
  assign lk_tag  = if_pc[DATA_W-1:INDEX_W+2];
  assign res_idx = res_pc[INDEX_W+1:2];
  assign res_tag = res_pc[DATA_W-1:INDEX_W+2];

  // fetch-side lookup reads the pre-edge table, no bypass of a same-cycle update
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : if_pc + DATA_W'(PC_INCREASE);
  end

  // evaluate the branch condition from func3
  always_comb begin
    cond = 1'b0;
    case (res_func3)
      BEQ:     cond = (res_rs1 == res_rs2);
      BNE:     cond = (res_rs1 != res_rs2);
      BLT:     cond = ($signed(res_rs1) <  $signed(res_rs2));
      BGE:     cond = ($signed(res_rs1) >= $signed(res_rs2));
      BLTU:    cond = (res_rs1 <  res_rs2);
      BGEU:    cond = (res_rs1 >= res_rs2);
      default: cond = 1'b0;
    endcase
  end

  // actual outcome, mispredict flag and redirect address
  always_comb begin
    res_taken       = res_is_jump | cond;
    res_target      = res_pc + res_imm;
    res_fallthrough = res_pc + DATA_W'(PC_INCREASE);
    res_hit         = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    res_redirect_pc = res_taken ? res_target : res_fallthrough;
    res_mispredict  = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_pred_target != res_target)));
  end

  bp_sat_counter u_ctr (
    .ctr      (ctr_q[res_idx]),
    .inc      (res_taken),
    .force_st (res_is_jump),
    .ctr_next (ctr_next)
  );

  // valid/counter training; reset wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (res_valid) begin
      if (res_hit) begin
        ctr_q[res_idx] <= ctr_next;
      end else if (res_taken) begin
        valid_q[res_idx] <= 1'b1;
        ctr_q[res_idx]   <= res_is_jump ? ST : WT;
      end
    end
  end

  // tag/target write on any taken resolve; tag only changes on allocation
  always_ff @(posedge clk) begin
    if (!rst && res_valid && res_taken) begin
      target_q[res_idx] <= res_target;
      if (!res_hit) tag_q[res_idx] <= res_tag;
    end
  end

`ifdef BP_STATS_EN
  // saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid && stat_branches != 16'hFFFF)
        stat_branches <= stat_branches + 16'd1;
      if (res_mispredict && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - directed and randomized checks of branch_predictor_btb
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        res_valid;
  logic [15:0] res_pc;
  logic [15:0] res_imm;
  logic [2:0]  res_func3;
  logic        res_is_jump;
  logic [15:0] res_rs1;
  logic [15:0] res_rs2;
  logic        res_pred_taken;
  logic [15:0] res_pred_target;
  logic        res_mispredict;
  logic [15:0] res_redirect_pc;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: per-slot record keyed by (pc/4) mod 16, tag = pc/64
  bit m_valid  [16];
  int m_tag    [16];
  int m_target [16];
  int m_ctr    [16];
  int m_br;
  int m_mp;

  branch_predictor_btb dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_imm         (res_imm),
    .res_func3       (res_func3),
    .res_is_jump     (res_is_jump),
    .res_rs1         (res_rs1),
    .res_rs2         (res_rs2),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .res_mispredict  (res_mispredict),
`ifdef BP_STATS_EN
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .res_redirect_pc (res_redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic int sgn(int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic bit outcome(int f3, int a, int b, bit j);
    if (j) return 1'b1;
    case (f3)
      0: return a == b;
      1: return a != b;
      4: return sgn(a) < sgn(b);
      5: return sgn(a) >= sgn(b);
      6: return a < b;
      7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // at negedge: compare all outputs with the model, update model, advance past the edge
  task automatic cycle();
    int li, lt, ri, rtg, rt, ft, pc, r;
    bit hit, tk, rtaken, mp, rhit;
    pc = int'(if_pc);
    li = (pc >> 2) % 16;
    lt = pc >> 6;
    hit = m_valid[li] && (m_tag[li] == lt);
    tk  = hit && (m_ctr[li] >= 2);
    check("pred_hit", {31'b0, pred_hit}, {31'b0, hit});
    check("pred_taken", {31'b0, pred_taken}, {31'b0, tk});
    check("pred_target", {16'b0, pred_target}, tk ? m_target[li] : (pc + 4) % 65536);
    r      = int'(res_pc);
    rtaken = outcome(int'(res_func3), int'(res_rs1), int'(res_rs2), res_is_jump);
    rt     = (r + int'(res_imm)) % 65536;
    ft     = (r + 4) % 65536;
    mp     = res_valid && ((rtaken != res_pred_taken) ||
                           (rtaken && int'(res_pred_target) != rt));
    check("res_mispredict", {31'b0, res_mispredict}, {31'b0, mp});
    check("res_redirect_pc", {16'b0, res_redirect_pc}, rtaken ? rt : ft);
`ifdef BP_STATS_EN
    check("stat_branches", {16'b0, stat_branches}, m_br);
    check("stat_mispredicts", {16'b0, stat_mispredicts}, m_mp);
`endif
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_br = 0;
      m_mp = 0;
    end else if (res_valid) begin
      if (m_br < 65535) m_br++;
      if (mp && m_mp < 65535) m_mp++;
      ri   = (r >> 2) % 16;
      rtg  = r >> 6;
      rhit = m_valid[ri] && (m_tag[ri] == rtg);
      if (rhit) begin
        if (res_is_jump) m_ctr[ri] = 3;
        else if (rtaken) m_ctr[ri] = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
        else m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
        if (rtaken) m_target[ri] = rt;
      end else if (rtaken) begin
        m_valid[ri]  = 1'b1;
        m_tag[ri]    = rtg;
        m_target[ri] = rt;
        m_ctr[ri]    = res_is_jump ? 3 : 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    cycle();
  endtask

  initial begin
    m_br = 0;
    m_mp = 0;
    rst = 1'b1; if_pc = 16'h0; res_valid = 1'b0; res_pc = 16'h0; res_imm = 16'h0;
    res_func3 = 3'b0; res_is_jump = 1'b0; res_rs1 = 16'h0; res_rs2 = 16'h0;
    res_pred_taken = 1'b0; res_pred_target = 16'h0;
    @(posedge clk); #1;
    step();
    rst = 1'b0;

    // reset state
    if_pc = 16'h0040;
    settle();
    check("rst_hit", {31'b0, pred_hit}, 0);
    check("rst_taken", {31'b0, pred_taken}, 0);
    check("rst_target", {16'b0, pred_target}, 32'h44);
    check("rst_mp", {31'b0, res_mispredict}, 0);
    cycle();

    // first taken BEQ allocates
    res_valid = 1'b1; res_pc = 16'h0040; res_imm = 16'h0010; res_func3 = 3'b000;
    res_rs1 = 16'd5; res_rs2 = 16'd5; res_pred_taken = 1'b0; res_pred_target = 16'h0;
    settle();
    check("beq_mp", {31'b0, res_mispredict}, 1);
    check("beq_redirect", {16'b0, res_redirect_pc}, 32'h50);
    cycle();
    res_valid = 1'b0;
    settle();
    check("alloc_hit", {31'b0, pred_hit}, 1);
    check("alloc_taken", {31'b0, pred_taken}, 1);
    check("alloc_target", {16'b0, pred_target}, 32'h50);
    cycle();

    // two not-taken resolves drop prediction, third saturates at 00
    res_valid = 1'b1; res_rs2 = 16'd6; res_pred_taken = 1'b1; res_pred_target = 16'h0050;
    step();
    step();
    res_valid = 1'b0;
    settle();
    check("nt_hit", {31'b0, pred_hit}, 1);
    check("nt_taken", {31'b0, pred_taken}, 0);
    cycle();
    res_valid = 1'b1; res_pred_taken = 1'b0;
    step();
    res_rs2 = 16'd5;
    step();
    res_valid = 1'b0;
    settle();
    check("sat_low_taken", {31'b0, pred_taken}, 0);
    cycle();

    // signed vs unsigned less-than
    res_valid = 1'b1; res_pc = 16'h0100; res_imm = 16'h0020; res_func3 = 3'b100;
    res_rs1 = 16'hFFFF; res_rs2 = 16'h0001; res_pred_taken = 1'b0;
    settle();
    check("blt_redirect", {16'b0, res_redirect_pc}, 32'h120);
    check("blt_mp", {31'b0, res_mispredict}, 1);
    cycle();
    res_func3 = 3'b110;
    settle();
    check("bltu_redirect", {16'b0, res_redirect_pc}, 32'h104);
    check("bltu_mp", {31'b0, res_mispredict}, 0);
    cycle();

    // aliasing 0x0040 / 0x0080
    res_func3 = 3'b000; res_rs1 = 16'd3; res_rs2 = 16'd3; res_imm = 16'h0008;
    res_pc = 16'h0040;
    step();
    res_pc = 16'h0080;
    step();
    res_valid = 1'b0; if_pc = 16'h0040;
    settle();
    check("alias_old_hit", {31'b0, pred_hit}, 0);
    cycle();
    if_pc = 16'h0080;
    settle();
    check("alias_new_hit", {31'b0, pred_hit}, 1);
    check("alias_new_target", {16'b0, pred_target}, 32'h88);
    cycle();

    // same-cycle update and lookup of index 3
    if_pc = 16'h000C; res_valid = 1'b1; res_pc = 16'h000C; res_is_jump = 1'b1; res_imm = 16'h0030;
    settle();
    check("same_cycle_hit", {31'b0, pred_hit}, 0);
    cycle();
    res_valid = 1'b0;
    settle();
    check("next_cycle_hit", {31'b0, pred_hit}, 1);
    check("next_cycle_target", {16'b0, pred_target}, 32'h3C);
    cycle();

    // reset beats a same-cycle update
    rst = 1'b1; res_valid = 1'b1; res_pc = 16'h001C;
    step();
    rst = 1'b0; res_valid = 1'b0; res_is_jump = 1'b0; if_pc = 16'h000C;
    settle();
    check("rst_clear_0c", {31'b0, pred_hit}, 0);
    cycle();
    if_pc = 16'h001C;
    settle();
    check("rst_clear_1c", {31'b0, pred_hit}, 0);
    cycle();

    // three resolves, one mispredict
    res_valid = 1'b1; res_pc = 16'h0200; res_func3 = 3'b000; res_rs1 = 16'd1; res_rs2 = 16'd2;
    res_pred_taken = 1'b0;
    step();
    step();
    res_rs2 = 16'd1;
    step();
    res_valid = 1'b0;
    settle();
`ifdef BP_STATS_EN
    check("stat_br_3", {16'b0, stat_branches}, 3);
    check("stat_mp_1", {16'b0, stat_mispredicts}, 1);
`endif
    cycle();

    // randomized traffic over an aliasing-heavy PC pool
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      res_valid = ($urandom_range(0, 3) != 0);
      if_pc     = 16'(($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 6));
      res_pc    = ($urandom_range(0, 9) == 0) ? 16'($urandom) & 16'hFFFC
                : 16'(($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 6));
      res_imm     = 16'($urandom) & 16'hFFFE;
      res_func3   = 3'($urandom_range(0, 7));
      res_is_jump = ($urandom_range(0, 7) == 0);
      res_rs1     = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      res_rs2     = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      res_pred_taken  = 1'($urandom_range(0, 1));
      res_pred_target = ($urandom_range(0, 2) != 0) ? res_pc + res_imm : 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
